// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle fetch/decode/execute/memory/writeback control FSM
module multicycle_control_unit #(
    parameter int OP_W = 6,
    parameter int ALUOP_W = 3,
    parameter logic [OP_W-1:0] OP_RTYPE = 6'b000000,
    parameter logic [OP_W-1:0] OP_LW    = 6'b100011,
    parameter logic [OP_W-1:0] OP_SW    = 6'b101011,
    parameter logic [OP_W-1:0] OP_BEQ   = 6'b000100,
    parameter logic [OP_W-1:0] OP_ADDI  = 6'b001000,
    parameter logic [OP_W-1:0] OP_J     = 6'b000010
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               MemToReg,
    output logic               MemWrite,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = '0;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d     = state_q;
        MemToReg    = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALU_ADD;
        PCSource    = 2'b00;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
                else if (op == OP_RTYPE)        state_d = S_EXEC;
                else if (op == OP_BEQ)          state_d = S_BRANCH;
                else if (op == OP_ADDI)         state_d = S_ADDIEX;
                else if (op == OP_J)            state_d = S_JUMP;
                else begin
                    illegal_op = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemToReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = mem_ready;
                instr_done = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset holds the state at FETCH, whose enables would otherwise follow mem_ready.
        if (!rst_n) begin
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            RegWrite    = 1'b0;
            instr_done  = 1'b0;
            illegal_op  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       mtr, mw, iord, irw, pcw, pcwc, srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       regdst, regw, done, ill;
        logic [3:0] st;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        int         fetch_stall;
        int         mem_stall;
        int         exp_cycles;
        int         exp_state;
        bit         exp_illegal;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [5:0] op;
    logic mem_ready;
    logic MemToReg, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic RegDst, RegWrite, instr_done, illegal_op;
    logic [3:0] state;

    int total = 0;
    int bad = 0;
    int path[$];
    ctl_t act, smp;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .MemToReg(MemToReg), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .RegDst(RegDst),
        .RegWrite(RegWrite), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    assign act = {MemToReg, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, ALUSrcA,
                  ALUSrcB, ALUOp, PCSource, RegDst, RegWrite, instr_done, illegal_op, state};

    function automatic bit is_legal(input logic [5:0] o);
        return o inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

    // Control word each state is documented to drive.
    function automatic ctl_t expect_ctl(input int s, input logic mr, input logic [5:0] o, input logic rst);
        ctl_t e = '0;
        e.st = s[3:0];
        case (s)
            0:  begin e.srcb = 2'b01; e.irw = mr; e.pcw = mr; end
            1:  begin e.srcb = 2'b11; e.ill = !is_legal(o); end
            2:  begin e.srca = 1'b1; e.srcb = 2'b10; end
            3:  e.iord = 1'b1;
            4:  begin e.mtr = 1'b1; e.regw = 1'b1; e.done = 1'b1; end
            5:  begin e.iord = 1'b1; e.mw = mr; e.done = mr; end
            6:  begin e.srca = 1'b1; e.aluop = 3'd2; end
            7:  begin e.regdst = 1'b1; e.regw = 1'b1; e.done = 1'b1; end
            8:  begin e.srca = 1'b1; e.aluop = 3'd1; e.pcwc = 1'b1; e.pcsrc = 2'b01; e.done = 1'b1; end
            9:  begin e.srca = 1'b1; e.srcb = 2'b10; end
            10: begin e.regw = 1'b1; e.done = 1'b1; end
            11: begin e.pcw = 1'b1; e.pcsrc = 2'b10; e.done = 1'b1; end
            default: ;
        endcase
        if (!rst) begin
            e.irw = 0; e.pcw = 0; e.pcwc = 0; e.mw = 0; e.regw = 0; e.done = 0; e.ill = 0;
        end
        return e;
    endfunction

    // Reference: a queue of the states the current instruction still has to visit.
    task automatic model_step(input logic [5:0] o, input logic mr);
        int s = path[0];
        if ((s == 0 || s == 3 || s == 5) && !mr) return;
        if (s == 0) path = '{1};
        else if (s == 1) begin
            case (o)
                OP_LW:    path = '{2, 3, 4};
                OP_SW:    path = '{2, 5};
                OP_RTYPE: path = '{6, 7};
                OP_BEQ:   path = '{8};
                OP_ADDI:  path = '{9, 10};
                OP_J:     path = '{11};
                default:  path = '{0};
            endcase
        end else begin
            void'(path.pop_front());
            if (path.size() == 0) path.push_back(0);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Entered just after a rising edge; compares on the falling edge, then advances the model.
    task automatic run_cycle(input logic [5:0] o, input logic mr);
        ctl_t e;
        op = o;
        mem_ready = mr;
        if (!rst_n) path = '{0};
        @(negedge clk);
        e = expect_ctl(path[0], mr, o, rst_n);
        smp = act;
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL ctl t=%0t: got %h want %h", $time, act, e);
        end
        @(posedge clk);
        if (rst_n) model_step(o, mr);
        #1;
    endtask

    vec_t vecs[12];
    logic [5:0] legal_ops[6];

    initial begin
        int cyc, fs, ms, s;
        bit seen, saw_regw;
        logic [5:0] inst_op, o;

        vecs[0]  = '{OP_RTYPE, 0, 0, 4, 7, 0};
        vecs[1]  = '{OP_LW,    0, 0, 5, 4, 0};
        vecs[2]  = '{OP_SW,    0, 0, 4, 5, 0};
        vecs[3]  = '{OP_BEQ,   0, 0, 3, 8, 0};
        vecs[4]  = '{OP_ADDI,  0, 0, 4, 10, 0};
        vecs[5]  = '{OP_J,     0, 0, 3, 11, 0};
        vecs[6]  = '{OP_LW,    0, 2, 7, 4, 0};
        vecs[7]  = '{OP_SW,    0, 1, 5, 5, 0};
        vecs[8]  = '{OP_RTYPE, 2, 0, 6, 7, 0};
        vecs[9]  = '{OP_J,     1, 0, 4, 11, 0};
        vecs[10] = '{6'b111111, 0, 0, 2, 1, 1};
        vecs[11] = '{6'b010101, 1, 0, 3, 1, 1};
        legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

        rst_n = 1'b0;
        op = '0;
        mem_ready = 1'b1;
        path = '{0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) run_cycle(OP_RTYPE, 1'b1);
        check("reset_state", {28'd0, smp.st}, 32'd0);
        check("reset_enables", {27'd0, smp.irw, smp.pcw, smp.pcwc, smp.mw, smp.regw}, 32'd0);
        rst_n = 1'b1;
        run_cycle(OP_RTYPE, 1'b1);
        check("release_irw_pcw", {30'd0, smp.irw, smp.pcw}, 32'd3);
        run_cycle(OP_RTYPE, 1'b1);
        run_cycle(OP_RTYPE, 1'b1);
        run_cycle(OP_RTYPE, 1'b1);
        check("rtype_wb", {28'd0, smp.regw, smp.regdst, smp.done, 1'b0}, 32'he);

        foreach (vecs[k]) begin
            fs = vecs[k].fetch_stall;
            ms = vecs[k].mem_stall;
            seen = 0;
            cyc = 0;
            while (!seen && cyc < 30) begin
                logic mr;
                s = path[0];
                mr = 1'b1;
                if (s == 0 && fs > 0) begin mr = 1'b0; fs--; end
                if ((s == 3 || s == 5) && ms > 0) begin mr = 1'b0; ms--; end
                run_cycle(vecs[k].op, mr);
                cyc++;
                if (smp.done || smp.ill) seen = 1;
            end
            check($sformatf("vec%0d_cycles", k), cyc, vecs[k].exp_cycles);
            check($sformatf("vec%0d_state", k), {28'd0, smp.st}, vecs[k].exp_state);
            check($sformatf("vec%0d_kind", k), {30'd0, smp.ill, smp.done},
                  vecs[k].exp_illegal ? 32'd2 : 32'd1);
        end
        run_cycle(OP_RTYPE, 1'b1);
        check("back_to_fetch_after_illegal", {28'd0, smp.st}, 32'd0);

        // Async reset while waiting in MEMRD.
        while (path[0] != 0) run_cycle(OP_LW, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(OP_LW, 1'b1);
        run_cycle(OP_LW, 1'b0);
        check("in_memrd", {28'd0, state}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("async_reset_state", {28'd0, state}, 32'd0);
        saw_regw = RegWrite;
        for (int i = 0; i < 2; i++) begin
            run_cycle(OP_LW, 1'b1);
            saw_regw |= smp.regw;
        end
        rst_n = 1'b1;
        run_cycle(OP_LW, 1'b1);
        saw_regw |= smp.regw;
        check("post_reset_fetch", {28'd0, smp.st}, 32'd0);
        check("no_regwrite_after_abort", {31'd0, saw_regw}, 32'd0);

        inst_op = OP_RTYPE;
        for (int i = 0; i < 500; i++) begin
            s = path[0];
            if (s == 0) begin
                int k = $urandom_range(0, 6);
                inst_op = (k == 6) ? 6'($urandom) : legal_ops[k];
            end
            o = (s == 1 || s == 2) ? inst_op : 6'($urandom);
            run_cycle(o, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
